// File: rtl/fetch_predictor_pkg.sv
// Shared definitions for the fetch-stage branch predictor.
// Holds the default address width and the 2-bit counter encodings.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

package fetch_predictor_pkg;

    localparam int DEF_ADDR_WIDTH = `ADDR_WIDTH;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Saturating step of a 2-bit confidence counter.
    function automatic logic [1:0] ctr_next(
        input logic [1:0] ctr,
        input logic       taken
    );
        if (taken)
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/fetch_predictor_table.sv
// predictor_table: direct-mapped entry storage with one lookup read port
// and one write port (write-first bypass onto the lookup port).
// Ports: clk, reset (sync, loads RESET_VALUE everywhere),
//   read_index/read_data   - lookup port, bypassed by a same-index write
//   write_en/write_index/write_data - entry write
//   write_old              - current contents at write_index (read-before-write
//                            view used to build the merged entry)
module predictor_table #(
    parameter int ENTRIES  = 16,
    parameter int IDX_BITS = 4,
    parameter int WIDTH    = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_BITS-1:0] read_index,
    output logic [WIDTH-1:0]    read_data,
    input  logic                write_en,
    input  logic [IDX_BITS-1:0] write_index,
    input  logic [WIDTH-1:0]    write_data,
    output logic [WIDTH-1:0]    write_old
);

    logic [WIDTH-1:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++)
                mem[i] <= RESET_VALUE;
        end else if (write_en) begin
            mem[write_index] <= write_data;
        end
    end

    // Write-first: a lookup of the index being written sees the new entry.
    assign read_data = (write_en && write_index == read_index)
                     ? write_data : mem[read_index];

    assign write_old = mem[write_index];

endmodule

// File: rtl/fetch_predictor.sv
// fetch_predictor: one-cycle direct-mapped branch target predictor.
// Ports: clk, reset (sync, active-high), stall (hold outputs), pc (lookup),
//   update_valid/update_pc/update_target/update_taken (EX resolution),
//   predict_pc/predict_taken/predict_address (registered prediction).
// Macro FETCH_PREDICTOR_COUNTER_EN adds 2-bit counters; without it a tag hit
// alone predicts taken and a not-taken resolution invalidates the entry.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module fetch_predictor
    import fetch_predictor_pkg::*;
#(
    parameter int ENTRIES    = 16,
    parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  update_valid,
    input  logic [ADDR_WIDTH-1:0] update_pc,
    input  logic [ADDR_WIDTH-1:0] update_target,
    input  logic                  update_taken,
    output logic [ADDR_WIDTH-1:0] predict_pc,
    output logic                  predict_taken,
    output logic [ADDR_WIDTH-1:0] predict_address
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = ADDR_WIDTH - IDX_BITS;

`ifdef FETCH_PREDICTOR_COUNTER_EN
    localparam int CTR_BITS = 2;
`else
    localparam int CTR_BITS = 0;
`endif

    // Entry layout, MSB first: valid | tag | target | ctr (ctr optional).
    localparam int EW      = 1 + TAG_BITS + ADDR_WIDTH + CTR_BITS;
    localparam int TGT_LSB = CTR_BITS;
    localparam int TAG_LSB = CTR_BITS + ADDR_WIDTH;

`ifdef FETCH_PREDICTOR_COUNTER_EN
    localparam logic [EW-1:0] RESET_ENTRY = EW'(CTR_WNT);
`else
    localparam logic [EW-1:0] RESET_ENTRY = '0;
`endif

    logic [EW-1:0]         lk_entry;
    logic [EW-1:0]         old_entry;
    logic [EW-1:0]         wr_data;
    logic                  wr_en;
    logic [TAG_BITS-1:0]   lk_tag;
    logic [TAG_BITS-1:0]   up_tag;
    logic [ADDR_WIDTH-1:0] lk_target;
    logic                  lk_hit;
    logic                  lk_taken;
    logic                  up_hit;

    assign lk_tag    = pc[ADDR_WIDTH-1:IDX_BITS];
    assign up_tag    = update_pc[ADDR_WIDTH-1:IDX_BITS];
    assign lk_target = lk_entry[TGT_LSB +: ADDR_WIDTH];
    assign lk_hit    = lk_entry[EW-1]
                    && lk_entry[TAG_LSB +: TAG_BITS] == lk_tag;
    assign up_hit    = old_entry[EW-1]
                    && old_entry[TAG_LSB +: TAG_BITS] == up_tag;

`ifdef FETCH_PREDICTOR_COUNTER_EN
    logic [1:0] lk_ctr;
    assign lk_ctr   = lk_entry[1:0];
    assign lk_taken = lk_hit && (lk_ctr >= CTR_WT);
`else
    assign lk_taken = lk_hit;
`endif

    predictor_table #(
        .ENTRIES     (ENTRIES),
        .IDX_BITS    (IDX_BITS),
        .WIDTH       (EW),
        .RESET_VALUE (RESET_ENTRY)
    ) u_table (
        .clk         (clk),
        .reset       (reset),
        .read_index  (pc[IDX_BITS-1:0]),
        .read_data   (lk_entry),
        .write_en    (wr_en),
        .write_index (update_pc[IDX_BITS-1:0]),
        .write_data  (wr_data),
        .write_old   (old_entry)
    );

    // Merge the resolved branch into the entry at its index.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = old_entry;
        if (update_valid) begin
            if (up_hit) begin
                wr_en = 1'b1;
`ifdef FETCH_PREDICTOR_COUNTER_EN
                wr_data[1:0] = ctr_next(old_entry[1:0], update_taken);
                if (update_taken)
                    wr_data[TGT_LSB +: ADDR_WIDTH] = update_target;
`else
                if (update_taken)
                    wr_data[TGT_LSB +: ADDR_WIDTH] = update_target;
                else
                    wr_data[EW-1] = 1'b0;
`endif
            end else if (update_taken) begin
                // Allocate, replacing whatever alias lived at this index.
                wr_en = 1'b1;
                wr_data[EW-1]                  = 1'b1;
                wr_data[TAG_LSB +: TAG_BITS]   = up_tag;
                wr_data[TGT_LSB +: ADDR_WIDTH] = update_target;
`ifdef FETCH_PREDICTOR_COUNTER_EN
                wr_data[1:0] = CTR_WT;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            predict_pc      <= '0;
            predict_taken   <= 1'b0;
            predict_address <= '0;
        end else if (!stall) begin
            predict_pc      <= pc;
            predict_taken   <= lk_taken;
            predict_address <= lk_taken ? lk_target
                                        : pc + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fetch_predictor.sv
// Self-checking bench for fetch_predictor (ENTRIES=16, ADDR_WIDTH=16).
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_predictor;

    localparam int E = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [15:0] pc;
    logic        update_valid;
    logic [15:0] update_pc;
    logic [15:0] update_target;
    logic        update_taken;
    logic [15:0] predict_pc;
    logic        predict_taken;
    logic [15:0] predict_address;

    int passed = 0;
    int total  = 0;

    // Reference model: per-index valid/tag/target/counter.
    bit   mv   [E];
    int   mtag [E];
    int   mtgt [E];
    int   mctr [E];
    logic [32:0] exp_o;

    logic [32:0] obs;
    assign obs = {predict_pc, predict_taken, predict_address};

    fetch_predictor #(.ENTRIES(16), .ADDR_WIDTH(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .pc              (pc),
        .update_valid    (update_valid),
        .update_pc       (update_pc),
        .update_target   (update_target),
        .update_taken    (update_taken),
        .predict_pc      (predict_pc),
        .predict_taken   (predict_taken),
        .predict_address (predict_address)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        int i;
        int t;
        bit h;
        bit tk;
        if (reset) begin
            for (int k = 0; k < E; k++) begin
                mv[k]   = 1'b0;
                mctr[k] = 1;
            end
            exp_o = '0;
            return;
        end
        if (update_valid) begin
            i = int'(update_pc) % E;
            t = int'(update_pc) / E;
            h = mv[i] && mtag[i] == t;
`ifdef FETCH_PREDICTOR_COUNTER_EN
            if (h) begin
                if (update_taken) begin
                    mctr[i] = (mctr[i] == 3) ? 3 : mctr[i] + 1;
                    mtgt[i] = int'(update_target);
                end else begin
                    mctr[i] = (mctr[i] == 0) ? 0 : mctr[i] - 1;
                end
            end else if (update_taken) begin
                mv[i] = 1'b1; mtag[i] = t;
                mtgt[i] = int'(update_target); mctr[i] = 2;
            end
`else
            if (h) begin
                if (update_taken) mtgt[i] = int'(update_target);
                else mv[i] = 1'b0;
            end else if (update_taken) begin
                mv[i] = 1'b1; mtag[i] = t;
                mtgt[i] = int'(update_target);
            end
`endif
        end
        if (!stall) begin
            i = int'(pc) % E;
            t = int'(pc) / E;
            h = mv[i] && mtag[i] == t;
`ifdef FETCH_PREDICTOR_COUNTER_EN
            tk = h && mctr[i] >= 2;
`else
            tk = h;
`endif
            exp_o = {pc, tk, tk ? 16'(mtgt[i]) : 16'((int'(pc) + 1) % 65536)};
        end
    endtask

    task automatic cycle(input bit r, input bit s, input logic [15:0] p,
                         input bit uv, input logic [15:0] up,
                         input logic [15:0] ut, input bit utk);
        reset = r; stall = s; pc = p;
        update_valid = uv; update_pc = up;
        update_target = ut; update_taken = utk;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic lookup(input logic [15:0] p);
        cycle(0, 0, p, 0, 16'h0, 16'h0, 0);
    endtask

    task automatic upd(input logic [15:0] a, input logic [15:0] t, input bit tk);
        cycle(0, 0, 16'h0000, 1, a, t, tk);
    endtask

    task automatic test_reset();
        logic [32:0] e;
        cycle(1, 0, 16'h0012, 1, 16'h0012, 16'h0040, 1);
        e = '0;
        total++;
        if (obs !== e) $display("FAIL reset_outputs got %h exp %h", obs, e);
        else passed++;
        lookup(16'h0005);
        e = {16'h0005, 1'b0, 16'h0006};
        total++;
        if (obs !== e) $display("FAIL first_lookup got %h exp %h", obs, e);
        else passed++;
        lookup(16'h0012);
        e = {16'h0012, 1'b0, 16'h0013};
        total++;
        if (obs !== e) $display("FAIL reset_update_ignored got %h exp %h", obs, e);
        else passed++;
    endtask

    task automatic test_alloc();
        logic [32:0] e;
        upd(16'h0012, 16'h0040, 1);
        lookup(16'h0012);
        e = {16'h0012, 1'b1, 16'h0040};
        total++;
        if (obs !== e) $display("FAIL alloc_hit got %h exp %h", obs, e);
        else passed++;
        lookup(16'h0022);
        e = {16'h0022, 1'b0, 16'h0023};
        total++;
        if (obs !== e) $display("FAIL alias_miss got %h exp %h", obs, e);
        else passed++;
    endtask

    task automatic test_counter();
        logic [32:0] e;
        upd(16'h0012, 16'h0000, 0);
        upd(16'h0012, 16'h0000, 0);
        lookup(16'h0012);
        e = {16'h0012, 1'b0, 16'h0013};
        total++;
        if (obs !== e) $display("FAIL two_not_taken got %h exp %h", obs, e);
        else passed++;
        for (int k = 0; k < 3; k++) upd(16'h0012, 16'h0040, 1);
        lookup(16'h0012);
        e = {16'h0012, 1'b1, 16'h0040};
        total++;
        if (obs !== e) $display("FAIL three_taken got %h exp %h", obs, e);
        else passed++;
        upd(16'h0012, 16'h0000, 0);
        lookup(16'h0012);
`ifdef FETCH_PREDICTOR_COUNTER_EN
        e = {16'h0012, 1'b1, 16'h0040};
`else
        e = {16'h0012, 1'b0, 16'h0013};
`endif
        total++;
        if (obs !== e) $display("FAIL one_not_taken got %h exp %h", obs, e);
        else passed++;
    endtask

    task automatic test_write_first();
        logic [32:0] e;
        cycle(0, 0, 16'h0030, 1, 16'h0030, 16'h0100, 1);
        e = {16'h0030, 1'b1, 16'h0100};
        total++;
        if (obs !== e) $display("FAIL write_first got %h exp %h", obs, e);
        else passed++;
    endtask

    task automatic test_stall();
        logic [32:0] e;
        logic [15:0] p;
        lookup(16'h0012);
`ifdef FETCH_PREDICTOR_COUNTER_EN
        e = {16'h0012, 1'b1, 16'h0040};
`else
        e = {16'h0012, 1'b0, 16'h0013};
`endif
        for (int k = 0; k < 3; k++) begin
            p = 16'h0012 + 16'(k);
            if (k == 0) cycle(0, 1, p, 1, 16'h0050, 16'h0077, 1);
            else cycle(0, 1, p, 0, 16'h0, 16'h0, 0);
            total++;
            if (obs !== e) $display("FAIL stall_hold%0d got %h exp %h", k, obs, e);
            else passed++;
        end
        lookup(16'h0050);
        e = {16'h0050, 1'b1, 16'h0077};
        total++;
        if (obs !== e) $display("FAIL stall_update got %h exp %h", obs, e);
        else passed++;
        lookup(16'hFFFF);
        e = {16'hFFFF, 1'b0, 16'h0000};
        total++;
        if (obs !== e) $display("FAIL pc_wrap got %h exp %h", obs, e);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [32:0] e;
        upd(16'h0012, 16'h0040, 1);
        cycle(1, 0, 16'h0012, 0, 16'h0, 16'h0, 0);
        e = '0;
        total++;
        if (obs !== e) $display("FAIL mid_reset_outputs got %h exp %h", obs, e);
        else passed++;
        lookup(16'h0012);
        e = {16'h0012, 1'b0, 16'h0013};
        total++;
        if (obs !== e) $display("FAIL mid_reset_forget got %h exp %h", obs, e);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] tg [8];
        logic [15:0] a;
        logic [32:0] e;
        for (int k = 0; k < 8; k++) begin
            tg[k] = 16'($urandom);
            upd(16'h0101 + 16'(k), tg[k], 1);
        end
        for (int k = 0; k < 8; k++) begin
            a = 16'h0101 + 16'(k);
            lookup(a);
            e = {a, 1'b1, tg[k]};
            total++;
            if (obs !== e) $display("FAIL b2b_%0d got %h exp %h", k, obs, e);
            else passed++;
        end
    endtask

    function automatic logic [15:0] rand_addr();
        int tags [4];
        tags = '{0, 1, 2, 4095};
        return 16'(tags[$urandom % 4] * 16 + int'($urandom % 16));
    endfunction

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom % 97) == 0, ($urandom % 4) == 0, rand_addr(),
                  1'($urandom % 2), rand_addr(), 16'($urandom),
                  ($urandom % 3) != 0);
            total++;
            if (obs !== exp_o) $display("FAIL random_%0d got %h exp %h", k, obs, exp_o);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_counter();
        test_write_first();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
